// File: rtl/qam_pkg.sv
// Shared definitions for the QAM16 feeder path: framer states, idle symbol and
// preamble patterns.
package qam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SEND_HI,
        SEND_LO
    } framer_state_t;

    // Lowest-energy-neutral mapper point, agreed as the between-burst symbol.
    localparam logic [3:0] IDLE_SYMBOL    = 4'b0000;
    localparam logic [3:0] PREAMBLE_ONES  = 4'b1111;
    localparam logic [3:0] PREAMBLE_ZEROS = 4'b0000;

endpackage

// File: rtl/qam_byte_fifo.sv
// Show-ahead synchronous FIFO: rdata is valid combinationally whenever !empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module qam_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/qam_symbol_framer.sv
// Byte-to-symbol framer feeding the QAM16 modulator on a fixed symbol-rate grid.
// Optional burst preamble is compiled in with `define QAM_FRAMER_PREAMBLE_EN.
module qam_symbol_framer
    import qam_pkg::*;
#(
    parameter int QAM_WIDTH     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SYMBOL_PERIOD = 16,
    parameter int PREAMBLE_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*QAM_WIDTH-1:0] byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic [QAM_WIDTH-1:0]   symbol_out,
    output logic                   symbol_strobe,
    output logic                   symbol_active
);

    localparam int CW = $clog2(SYMBOL_PERIOD);
    localparam logic [QAM_WIDTH-1:0] SYM_IDLE  = QAM_WIDTH'(IDLE_SYMBOL);
    localparam logic [QAM_WIDTH-1:0] SYM_ONES  = QAM_WIDTH'(PREAMBLE_ONES);
    localparam logic [QAM_WIDTH-1:0] SYM_ZEROS = QAM_WIDTH'(PREAMBLE_ZEROS);

    if (SYMBOL_PERIOD < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PREAMBLE_LEN < 1) begin : g_param_check
        $error("qam_symbol_framer: illegal parameter set");
    end

    logic [CW-1:0]          sym_cnt;
    logic                   tick;
    framer_state_t          state, state_next;
    logic [QAM_WIDTH-1:0]   lo_q, lo_next;
    logic [QAM_WIDTH-1:0]   sym_next;
    logic                   active_next;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [2*QAM_WIDTH-1:0] fifo_rdata;

    assign tick       = (sym_cnt == CW'(SYMBOL_PERIOD - 1));
    assign byte_ready = !fifo_full;

    qam_byte_fifo #(.WIDTH(2*QAM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (byte_valid && byte_ready),
        .pop   (fifo_pop),
        .wdata (byte_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sym_cnt <= '0;
        else if (tick)
            sym_cnt <= '0;
        else
            sym_cnt <= sym_cnt + 1'b1;
    end

`ifdef QAM_FRAMER_PREAMBLE_EN
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    // Counts preamble symbols already emitted in the current burst.
    logic [PW-1:0] pre_cnt, pre_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_next;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lo_q          <= '0;
            symbol_out    <= SYM_IDLE;
            symbol_active <= 1'b0;
            symbol_strobe <= 1'b0;
        end else begin
            state         <= state_next;
            lo_q          <= lo_next;
            symbol_out    <= sym_next;
            symbol_active <= active_next;
            symbol_strobe <= tick;
        end
    end

    // NOTE: every signal gets a default before the case, so no path infers a latch.
    always_comb begin
        state_next  = state;
        lo_next     = lo_q;
        sym_next    = symbol_out;
        active_next = symbol_active;
        fifo_pop    = 1'b0;
`ifdef QAM_FRAMER_PREAMBLE_EN
        pre_next    = pre_cnt;
`endif
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (fifo_empty) begin
                        sym_next    = SYM_IDLE;
                        active_next = 1'b0;
                    end else begin
`ifdef QAM_FRAMER_PREAMBLE_EN
                        state_next  = PREAMBLE;
                        sym_next    = SYM_ONES;
                        active_next = 1'b1;
                        pre_next    = PW'(1);
`else
                        fifo_pop    = 1'b1;
                        sym_next    = fifo_rdata[2*QAM_WIDTH-1:QAM_WIDTH];
                        lo_next     = fifo_rdata[QAM_WIDTH-1:0];
                        active_next = 1'b1;
                        state_next  = SEND_HI;
`endif
                    end
                end
                PREAMBLE: begin
`ifdef QAM_FRAMER_PREAMBLE_EN
                    // The byte that opened the burst is still at the FIFO head.
                    if (pre_cnt == PW'(PREAMBLE_LEN)) begin
                        fifo_pop    = 1'b1;
                        sym_next    = fifo_rdata[2*QAM_WIDTH-1:QAM_WIDTH];
                        lo_next     = fifo_rdata[QAM_WIDTH-1:0];
                        active_next = 1'b1;
                        state_next  = SEND_HI;
                    end else begin
                        sym_next = pre_cnt[0] ? SYM_ZEROS : SYM_ONES;
                        pre_next = pre_cnt + 1'b1;
                    end
`else
                    state_next = IDLE;
`endif
                end
                SEND_HI: begin
                    sym_next   = lo_q;
                    state_next = SEND_LO;
                end
                SEND_LO: begin
                    if (fifo_empty) begin
                        sym_next    = SYM_IDLE;
                        active_next = 1'b0;
                        state_next  = IDLE;
                    end else begin
                        fifo_pop    = 1'b1;
                        sym_next    = fifo_rdata[2*QAM_WIDTH-1:QAM_WIDTH];
                        lo_next     = fifo_rdata[QAM_WIDTH-1:0];
                        active_next = 1'b1;
                        state_next  = SEND_HI;
                    end
                end
            endcase
        end
    end

endmodule
